// File: rtl/lc4_div_pkg.sv
// rtl/lc4_div_pkg.sv - shared types and widths for the LC4 sequential divider
package lc4_div_pkg;
  localparam int DIV_WIDTH = 16;
  localparam int DIV_ITERS = 16;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;
endpackage

// File: rtl/lc4_div_step.sv
// rtl/lc4_div_step.sv - one combinational restoring-division iteration
module lc4_div_step
  import lc4_div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [DIV_WIDTH-1:0] rem,
  input  logic [DIV_WIDTH-1:0] quo,
  output logic [DIV_WIDTH-1:0] dividend_next,
  output logic [DIV_WIDTH-1:0] rem_next,
  output logic [DIV_WIDTH-1:0] quo_next
);
  logic [DIV_WIDTH-1:0] rem_shift;
  logic                 fits;

  // Width stays at 16 bits to match the LC4 reference divider bit for bit.
  always_comb begin
    rem_shift     = {rem[DIV_WIDTH-2:0], dividend[DIV_WIDTH-1]};
    fits          = (rem_shift >= divisor);
    rem_next      = fits ? (rem_shift - divisor) : rem_shift;
    quo_next      = {quo[DIV_WIDTH-2:0], fits};
    dividend_next = {dividend[DIV_WIDTH-2:0], 1'b0};
  end
endmodule

// File: rtl/lc4_div_sequencer.sv
// rtl/lc4_div_sequencer.sv - multicycle LC4 DIV/MOD sequencer; LC4_DIV_EARLY_OUT_EN enables trivial-operand bypass
module lc4_div_sequencer
  import lc4_div_pkg::*;
#(
  parameter int ITERS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [DIV_WIDTH-1:0] i_dividend,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  output logic                 o_ready,
  output logic                 o_valid,
  input  logic                 i_ack,
  output logic [DIV_WIDTH-1:0] o_quotient,
  output logic [DIV_WIDTH-1:0] o_remainder,
  output logic                 o_busy
);
  if (!(ITERS_PER_CYCLE == 1 || ITERS_PER_CYCLE == 2 || ITERS_PER_CYCLE == 4 ||
        ITERS_PER_CYCLE == 8 || ITERS_PER_CYCLE == 16)) begin : g_bad_iters
    $error("lc4_div_sequencer: ITERS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [CNT_W-1:0] ITER_INC = CNT_W'(ITERS_PER_CYCLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS);

  div_state_t           state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_next;
  logic                 last_step;
  logic                 early_out;
  logic [DIV_WIDTH-1:0] dvd_r, rem_r, quo_r, divisor_r;

  logic [DIV_WIDTH-1:0] c_dvd [ITERS_PER_CYCLE+1];
  logic [DIV_WIDTH-1:0] c_rem [ITERS_PER_CYCLE+1];
  logic [DIV_WIDTH-1:0] c_quo [ITERS_PER_CYCLE+1];

  assign c_dvd[0] = dvd_r;
  assign c_rem[0] = rem_r;
  assign c_quo[0] = quo_r;

  for (genvar g = 0; g < ITERS_PER_CYCLE; g++) begin : g_step
    lc4_div_step u_step (
      .dividend      (c_dvd[g]),
      .divisor       (divisor_r),
      .rem           (c_rem[g]),
      .quo           (c_quo[g]),
      .dividend_next (c_dvd[g+1]),
      .rem_next      (c_rem[g+1]),
      .quo_next      (c_quo[g+1])
    );
  end

  assign cnt_next  = cnt + ITER_INC;
  assign last_step = (cnt_next == CNT_LAST);

`ifdef LC4_DIV_EARLY_OUT_EN
  assign early_out = (i_divisor == '0) || (i_dividend < i_divisor);
`else
  assign early_out = 1'b0;
`endif

  assign o_ready = (state == IDLE);
  assign o_busy  = (state == BUSY);
  assign o_valid = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start) state_next = early_out ? DONE : BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (i_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      dvd_r       <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      divisor_r   <= '0;
      o_quotient  <= '0;
      o_remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            dvd_r     <= i_dividend;
            divisor_r <= i_divisor;
            rem_r     <= '0;
            quo_r     <= '0;
            cnt       <= '0;
            // Bypass result: zero divisor gives 0/0, otherwise dividend is the remainder.
            if (early_out) begin
              o_quotient  <= '0;
              o_remainder <= (i_divisor == '0) ? '0 : i_dividend;
            end
          end
        end
        BUSY: begin
          dvd_r <= c_dvd[ITERS_PER_CYCLE];
          rem_r <= c_rem[ITERS_PER_CYCLE];
          quo_r <= c_quo[ITERS_PER_CYCLE];
          cnt   <= cnt_next;
          // Divide-by-zero is squashed only here; the steps run unguarded.
          if (last_step) begin
            o_quotient  <= (divisor_r == '0) ? '0 : c_quo[ITERS_PER_CYCLE];
            o_remainder <= (divisor_r == '0) ? '0 : c_rem[ITERS_PER_CYCLE];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lc4_div_sequencer.sv
// tb/tb_lc4_div_sequencer.sv - directed self-checking bench for lc4_div_sequencer
module tb_lc4_div_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dividend = '0;
  logic [15:0] divisor  = '0;
  logic [2:0]  start_v  = '0;
  logic [2:0]  ack_v    = '0;
  logic [2:0]  ready_v, valid_v, busy_v;
  logic [15:0] quo_v [3];
  logic [15:0] rem_v [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lc4_div_sequencer #(.ITERS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .i_start(start_v[0]), .i_dividend(dividend), .i_divisor(divisor),
    .o_ready(ready_v[0]), .o_valid(valid_v[0]), .i_ack(ack_v[0]),
    .o_quotient(quo_v[0]), .o_remainder(rem_v[0]), .o_busy(busy_v[0]));

  lc4_div_sequencer #(.ITERS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .i_start(start_v[1]), .i_dividend(dividend), .i_divisor(divisor),
    .o_ready(ready_v[1]), .o_valid(valid_v[1]), .i_ack(ack_v[1]),
    .o_quotient(quo_v[1]), .o_remainder(rem_v[1]), .o_busy(busy_v[1]));

  lc4_div_sequencer #(.ITERS_PER_CYCLE(16)) dut16 (
    .clk(clk), .rst(rst), .i_start(start_v[2]), .i_dividend(dividend), .i_divisor(divisor),
    .o_ready(ready_v[2]), .o_valid(valid_v[2]), .i_ack(ack_v[2]),
    .o_quotient(quo_v[2]), .o_remainder(rem_v[2]), .o_busy(busy_v[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int n_of(input int sel);
    return (sel == 0) ? 16 : (sel == 1) ? 4 : 1;
  endfunction

  function automatic int exp_lat(input int sel, input logic [15:0] a, input logic [15:0] b);
`ifdef LC4_DIV_EARLY_OUT_EN
    if (b == 16'd0 || a < b) return 1;
`endif
    return n_of(sel) + 1;
  endfunction

  // lat counts clock edges from the accept edge (inclusive) until o_valid is seen.
  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                        input int pulse_at, output int lat, output int busy_bad);
    int wait_c = 0;
    while (ready_v[sel] !== 1'b1 && wait_c < 64) begin
      tick();
      wait_c++;
    end
    dividend     = a;
    divisor      = b;
    start_v[sel] = 1'b1;
    tick();
    start_v[sel] = 1'b0;
    dividend     = 16'($urandom);
    divisor      = 16'($urandom);
    lat          = 1;
    busy_bad     = 0;
    while (valid_v[sel] !== 1'b1 && lat < 64) begin
      if (busy_v[sel] !== 1'b1 || ready_v[sel] !== 1'b0) busy_bad++;
      if (lat == pulse_at) start_v[sel] = 1'b1;
      tick();
      start_v[sel] = 1'b0;
      lat++;
    end
  endtask

  task automatic do_ack(input int sel);
    ack_v[sel] = 1'b1;
    tick();
    ack_v[sel] = 1'b0;
    tests++;
    if (ready_v[sel] !== 1'b1 || valid_v[sel] !== 1'b0) begin
      fails++;
      $display("FAIL ack_to_idle[%0d]: ready=%b valid=%b, expected ready=1 valid=0",
               sel, ready_v[sel], valid_v[sel]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tests++;
      if (ready_v[s] !== 1'b1 || valid_v[s] !== 1'b0 || busy_v[s] !== 1'b0 ||
          quo_v[s] !== 16'd0 || rem_v[s] !== 16'd0) begin
        fails++;
        $display("FAIL reset[%0d]: ready=%b valid=%b busy=%b q=%0d r=%0d, expected 1 0 0 0 0",
                 s, ready_v[s], valid_v[s], busy_v[s], quo_v[s], rem_v[s]);
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0] va [4] = '{16'd100, 16'd65535, 16'h8000, 16'd5};
    logic [15:0] vb [4] = '{16'd7,   16'd1,     16'h00FF, 16'd0};
    logic [15:0] vq [4] = '{16'd14,  16'd65535, 16'd128,  16'd0};
    logic [15:0] vr [4] = '{16'd2,   16'd0,     16'd128,  16'd0};
    int lat, bb;
    for (int i = 0; i < 4; i++) begin
      run_op(0, va[i], vb[i], -1, lat, bb);
      tests++;
      if (lat !== exp_lat(0, va[i], vb[i]) || bb !== 0) begin
        fails++;
        $display("FAIL basic_timing %0d/%0d: latency=%0d busy_errs=%0d, expected latency=%0d busy_errs=0",
                 va[i], vb[i], lat, bb, exp_lat(0, va[i], vb[i]));
      end
      tests++;
      if (quo_v[0] !== vq[i] || rem_v[0] !== vr[i]) begin
        fails++;
        $display("FAIL basic_result %0d/%0d: q=%0d r=%0d, expected q=%0d r=%0d",
                 va[i], vb[i], quo_v[0], rem_v[0], vq[i], vr[i]);
      end
      do_ack(0);
    end
  endtask

  task automatic test_backpressure();
    int lat, bb;
    run_op(0, 16'd1000, 16'd33, 3, lat, bb);
    tests++;
    if (lat !== 17 || quo_v[0] !== 16'd30 || rem_v[0] !== 16'd10) begin
      fails++;
      $display("FAIL bp_result: latency=%0d q=%0d r=%0d, expected latency=17 q=30 r=10",
               lat, quo_v[0], rem_v[0]);
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        dividend   = 16'd1;
        divisor    = 16'd1;
        start_v[0] = 1'b1;
      end
      tick();
      start_v[0] = 1'b0;
      tests++;
      if (valid_v[0] !== 1'b1 || quo_v[0] !== 16'd30 || rem_v[0] !== 16'd10) begin
        fails++;
        $display("FAIL bp_hold cycle %0d: valid=%b q=%0d r=%0d, expected valid=1 q=30 r=10",
                 c, valid_v[0], quo_v[0], rem_v[0]);
      end
    end
    do_ack(0);
    tests++;
    if (quo_v[0] !== 16'd30 || rem_v[0] !== 16'd10) begin
      fails++;
      $display("FAIL idle_hold: q=%0d r=%0d, expected q=30 r=10", quo_v[0], rem_v[0]);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, bb;
    dividend   = 16'd200;
    divisor    = 16'd3;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (busy_v[0] !== 1'b0 || valid_v[0] !== 1'b0 || ready_v[0] !== 1'b1 ||
        quo_v[0] !== 16'd0 || rem_v[0] !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid_op: busy=%b valid=%b ready=%b q=%0d r=%0d, expected 0 0 1 0 0",
               busy_v[0], valid_v[0], ready_v[0], quo_v[0], rem_v[0]);
    end
    run_op(0, 16'd9, 16'd4, -1, lat, bb);
    tests++;
    if (lat !== 17 || quo_v[0] !== 16'd2 || rem_v[0] !== 16'd1) begin
      fails++;
      $display("FAIL after_reset 9/4: latency=%0d q=%0d r=%0d, expected latency=17 q=2 r=1",
               lat, quo_v[0], rem_v[0]);
    end
    do_ack(0);
  endtask

  task automatic test_back_to_back();
    int lat, bb;
    run_op(0, 16'd100, 16'd7, -1, lat, bb);
    dividend   = 16'd50;
    divisor    = 16'd5;
    ack_v[0]   = 1'b1;
    start_v[0] = 1'b1;
    tick();
    ack_v[0]   = 1'b0;
    start_v[0] = 1'b0;
    tick();
    tests++;
    if (ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || valid_v[0] !== 1'b0) begin
      fails++;
      $display("FAIL ack_start_same_cycle: ready=%b busy=%b valid=%b, expected 1 0 0",
               ready_v[0], busy_v[0], valid_v[0]);
    end
    run_op(0, 16'd50, 16'd5, -1, lat, bb);
    tests++;
    if (lat !== 17 || quo_v[0] !== 16'd10 || rem_v[0] !== 16'd0) begin
      fails++;
      $display("FAIL b2b 50/5: latency=%0d q=%0d r=%0d, expected latency=17 q=10 r=0",
               lat, quo_v[0], rem_v[0]);
    end
    do_ack(0);
  endtask

  task automatic test_wide_iters();
    logic [15:0] va [3] = '{16'd12345, 16'd12345, 16'h8000};
    logic [15:0] vb [3] = '{16'd100,   16'd100,   16'h00FF};
    logic [15:0] vq [3] = '{16'd123,   16'd123,   16'd128};
    logic [15:0] vr [3] = '{16'd45,    16'd45,    16'd128};
    int          vs [3] = '{1, 2, 2};
    int          vl [3] = '{5, 2, 2};
    int lat, bb;
    for (int i = 0; i < 3; i++) begin
      run_op(vs[i], va[i], vb[i], -1, lat, bb);
      tests++;
      if (lat !== vl[i] || bb !== 0 || quo_v[vs[i]] !== vq[i] || rem_v[vs[i]] !== vr[i]) begin
        fails++;
        $display("FAIL wide[%0d] %0d/%0d: latency=%0d busy_errs=%0d q=%0d r=%0d, expected latency=%0d q=%0d r=%0d",
                 vs[i], va[i], vb[i], lat, bb, quo_v[vs[i]], rem_v[vs[i]], vl[i], vq[i], vr[i]);
      end
      do_ack(vs[i]);
    end
  endtask

  task automatic test_early_out();
    logic [15:0] va [4] = '{16'd3,  16'd7, 16'd100, 16'd3};
    logic [15:0] vb [4] = '{16'd10, 16'd0, 16'd7,   16'd10};
    logic [15:0] vq [4] = '{16'd0,  16'd0, 16'd14,  16'd0};
    logic [15:0] vr [4] = '{16'd3,  16'd0, 16'd2,   16'd3};
    int          vs [4] = '{0, 0, 0, 1};
    int lat, bb;
    for (int i = 0; i < 4; i++) begin
      run_op(vs[i], va[i], vb[i], -1, lat, bb);
      tests++;
      if (lat !== exp_lat(vs[i], va[i], vb[i]) || quo_v[vs[i]] !== vq[i] || rem_v[vs[i]] !== vr[i]) begin
        fails++;
        $display("FAIL early[%0d] %0d/%0d: latency=%0d q=%0d r=%0d, expected latency=%0d q=%0d r=%0d",
                 vs[i], va[i], vb[i], lat, quo_v[vs[i]], rem_v[vs[i]],
                 exp_lat(vs[i], va[i], vb[i]), vq[i], vr[i]);
      end
      do_ack(vs[i]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    test_wide_iters();
    test_early_out();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
